// File: rtl/calc_ctrl.sv
// Four-function decimal calculator controller: keypad entry, add/sub in one cycle,
// shift-add multiply and restoring divide over 20 cycles, registered display outputs.
module calc_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [19:0] number,
   output logic [2:0]  sign,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      OP      = 3'd1,
      ENTER_B = 3'd2,
      EXEC    = 3'd3,
      RESULT  = 3'd4,
      ERROR   = 3'd5
   } state_t;

   localparam logic [2:0]  SIGN_CLEAR = 3'b100;
   localparam logic [2:0]  SIGN_NUM   = 3'b101;
   localparam logic [2:0]  SIGN_ERR   = 3'b111;
   localparam logic [19:0] MAX_VAL    = 20'd999999;
   localparam logic [2:0]  MAX_DIGITS = 3'd6;

   state_t       state_r, state_n;
   logic [19:0]  op_a_r, op_a_n;
   logic [19:0]  op_b_r, op_b_n;
   logic [1:0]   op_r, op_n;
   logic [4:0]   cnt_r, cnt_n;
   logic [39:0]  acc_r, acc_n;
   logic [2:0]   dcnt_r, dcnt_n;
   logic [19:0]  number_n;
   logic [2:0]   sign_n;
   logic         busy_n, err_n;

   logic         is_digit_s, is_oper_s, is_clear_s, is_equal_s;
   logic [1:0]   key_op_s;
   logic [19:0]  digit_s;
   logic [20:0]  sum_s;
   logic [39:0]  mul_acc_s;
   logic [20:0]  div_trial_s;
   logic         div_ge_s;
   logic [19:0]  div_rem_s;
   logic [39:0]  div_acc_s;
   logic         last_iter_s;
   logic         exec_done_s, exec_fail_s;
   logic [19:0]  exec_res_s;

   // operand*10 + digit; the operand is at most 99999 here so 20 bits suffice
   function automatic logic [19:0] append_digit(input logic [19:0] v, input logic [19:0] d);
      append_digit = (v << 3) + (v << 1) + d;
   endfunction

   assign is_digit_s  = key_valid && (key_code <= 4'd9);
   assign is_oper_s   = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
   assign is_clear_s  = key_valid && (key_code == 4'd14);
   assign is_equal_s  = key_valid && (key_code == 4'd15);
   assign key_op_s    = {~key_code[1], key_code[0]};   // codes 10..13 -> 00..11
   assign digit_s     = {16'd0, key_code};
   assign last_iter_s = (cnt_r == 5'd19);

   assign sum_s       = {1'b0, op_a_r} + {1'b0, op_b_r};
   assign mul_acc_s   = acc_r + (op_b_r[cnt_r] ? ({20'd0, op_a_r} << cnt_r) : 40'd0);
   // divide: acc holds {remainder, dividend/quotient}, one quotient bit per cycle
   assign div_trial_s = {acc_r[39:20], acc_r[19]};
   assign div_ge_s    = (div_trial_s >= {1'b0, op_b_r});
   assign div_rem_s   = div_ge_s ? (div_trial_s[19:0] - op_b_r) : div_trial_s[19:0];
   assign div_acc_s   = {div_rem_s, acc_r[18:0], div_ge_s};

   // Execution step: decides whether this cycle finishes the operation, and how
   always_comb begin
      exec_done_s = 1'b0;
      exec_fail_s = 1'b0;
      exec_res_s  = 20'd0;
      case (op_r)
         2'b00: begin
            exec_done_s = 1'b1;
            exec_fail_s = (sum_s > {1'b0, MAX_VAL});
            exec_res_s  = sum_s[19:0];
         end
         2'b01: begin
            exec_done_s = 1'b1;
            exec_fail_s = (op_a_r < op_b_r);
            exec_res_s  = op_a_r - op_b_r;
         end
         2'b10: begin
            exec_done_s = last_iter_s;
            exec_fail_s = (mul_acc_s > {20'd0, MAX_VAL});
            exec_res_s  = mul_acc_s[19:0];
         end
         2'b11: begin
            if (op_b_r == 20'd0) begin
               exec_done_s = 1'b1;
               exec_fail_s = 1'b1;
            end else begin
               exec_done_s = last_iter_s;
               exec_fail_s = 1'b0;
               exec_res_s  = div_acc_s[19:0];
            end
         end
         default: begin
            exec_done_s = 1'b1;
            exec_fail_s = 1'b1;
         end
      endcase
   end

   // Next-state, datapath and display values
   always_comb begin
      state_n  = state_r;
      op_a_n   = op_a_r;
      op_b_n   = op_b_r;
      op_n     = op_r;
      cnt_n    = cnt_r;
      acc_n    = acc_r;
      dcnt_n   = dcnt_r;
      number_n = number;
      sign_n   = sign;
      busy_n   = busy;
      err_n    = err;

      if (is_clear_s) begin
         state_n  = ENTER_A;
         op_a_n   = 20'd0;
         op_b_n   = 20'd0;
         op_n     = 2'b00;
         cnt_n    = 5'd0;
         acc_n    = 40'd0;
         dcnt_n   = 3'd0;
         number_n = 20'd0;
         sign_n   = SIGN_CLEAR;
         busy_n   = 1'b0;
         err_n    = 1'b0;
      end else begin
         case (state_r)
            ENTER_A: begin
               if (is_digit_s) begin
                  if (dcnt_r < MAX_DIGITS) begin
                     op_a_n = append_digit(op_a_r, digit_s);
                     dcnt_n = dcnt_r + 3'd1;
                  end else begin
                     op_a_n = op_a_r;
                  end
                  number_n = op_a_n;
                  sign_n   = SIGN_NUM;
               end else if (is_oper_s) begin
                  op_n    = key_op_s;
                  sign_n  = {1'b0, key_op_s};
                  state_n = OP;
               end else begin
                  state_n = ENTER_A;
               end
            end
            OP: begin
               if (is_oper_s) begin
                  op_n   = key_op_s;
                  sign_n = {1'b0, key_op_s};
               end else if (is_digit_s) begin
                  op_b_n   = digit_s;
                  dcnt_n   = 3'd1;
                  number_n = digit_s;
                  sign_n   = SIGN_NUM;
                  state_n  = ENTER_B;
               end else begin
                  state_n = OP;
               end
            end
            ENTER_B: begin
               if (is_digit_s) begin
                  if (dcnt_r < MAX_DIGITS) begin
                     op_b_n = append_digit(op_b_r, digit_s);
                     dcnt_n = dcnt_r + 3'd1;
                  end else begin
                     op_b_n = op_b_r;
                  end
                  number_n = op_b_n;
               end else if (is_equal_s) begin
                  state_n = EXEC;
                  busy_n  = 1'b1;
                  cnt_n   = 5'd0;
                  acc_n   = (op_r == 2'b11) ? {20'd0, op_a_r} : 40'd0;
               end else begin
                  state_n = ENTER_B;
               end
            end
            EXEC: begin
               acc_n = (op_r == 2'b11) ? div_acc_s : mul_acc_s;
               cnt_n = cnt_r + 5'd1;
               if (exec_done_s && exec_fail_s) begin
                  state_n  = ERROR;
                  number_n = 20'd0;
                  sign_n   = SIGN_ERR;
                  busy_n   = 1'b0;
                  err_n    = 1'b1;
               end else if (exec_done_s) begin
                  state_n  = RESULT;
                  op_a_n   = exec_res_s;
                  number_n = exec_res_s;
                  sign_n   = SIGN_NUM;
                  busy_n   = 1'b0;
               end else begin
                  state_n = EXEC;
               end
            end
            RESULT: begin
               if (is_oper_s) begin
                  op_n    = key_op_s;
                  sign_n  = {1'b0, key_op_s};
                  state_n = OP;
               end else if (is_digit_s) begin
                  op_a_n   = digit_s;
                  dcnt_n   = 3'd1;
                  number_n = digit_s;
                  sign_n   = SIGN_NUM;
                  state_n  = ENTER_A;
               end else begin
                  state_n = RESULT;
               end
            end
            ERROR: begin
               if (is_digit_s) begin
                  op_a_n   = digit_s;
                  dcnt_n   = 3'd1;
                  number_n = digit_s;
                  sign_n   = SIGN_NUM;
                  err_n    = 1'b0;
                  state_n  = ENTER_A;
               end else begin
                  state_n = ERROR;
               end
            end
            default: begin
               state_n = ENTER_A;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ENTER_A;
         op_a_r  <= 20'd0;
         op_b_r  <= 20'd0;
         op_r    <= 2'b00;
         cnt_r   <= 5'd0;
         acc_r   <= 40'd0;
         dcnt_r  <= 3'd0;
         number  <= 20'd0;
         sign    <= SIGN_NUM;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_r <= state_n;
         op_a_r  <= op_a_n;
         op_b_r  <= op_b_n;
         op_r    <= op_n;
         cnt_r   <= cnt_n;
         acc_r   <= acc_n;
         dcnt_r  <= dcnt_n;
         number  <= number_n;
         sign    <= sign_n;
         busy    <= busy_n;
         err     <= err_n;
      end
   end

endmodule

// File: tb/tb_calc_ctrl.sv
// Testbench for calc_ctrl: directed key sequences, an arithmetic reference model
// compared on every cycle, and literal expectations for the key scenarios.
module tb_calc_ctrl;

   localparam int ADD = 10, SUB = 11, MUL = 12, DIV = 13, CLR = 14, EQ = 15;
   localparam int M_A = 0, M_OP = 1, M_B = 2, M_X = 3, M_R = 4, M_E = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [19:0] number;
   logic [2:0]  sign;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // reference model state
   int     m_mode, m_a, m_b, m_op, m_dig, m_wait, m_res;
   bit     m_fail;
   longint m_num;
   int     m_sign;
   bit     m_busy, m_err;

   calc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .number(number), .sign(sign), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_step(input bit rst, input bit kv, input int code);
      longint r;
      if (rst) begin
         m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_dig = 0;
         m_num = 0; m_sign = 5; m_busy = 0; m_err = 0;
      end else if (kv && code == CLR) begin
         m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_dig = 0;
         m_num = 0; m_sign = 4; m_busy = 0; m_err = 0;
      end else if (m_mode == M_X) begin
         m_wait--;
         if (m_wait == 0) begin
            m_busy = 0;
            if (m_fail) begin
               m_mode = M_E; m_num = 0; m_sign = 7; m_err = 1;
            end else begin
               m_mode = M_R; m_a = m_res; m_num = m_res; m_sign = 5;
            end
         end
      end else if (kv) begin
         case (m_mode)
            M_A: if (code <= 9) begin
                    if (m_dig < 6) begin m_a = m_a * 10 + code; m_dig++; end
                    m_num = m_a; m_sign = 5;
                 end else if (code <= DIV) begin
                    m_op = code - 10; m_sign = m_op; m_mode = M_OP;
                 end
            M_OP: if (code <= 9) begin
                     m_b = code; m_dig = 1; m_num = code; m_sign = 5; m_mode = M_B;
                  end else if (code <= DIV) begin
                     m_op = code - 10; m_sign = m_op;
                  end
            M_B: if (code <= 9) begin
                    if (m_dig < 6) begin m_b = m_b * 10 + code; m_dig++; end
                    m_num = m_b;
                 end else if (code == EQ) begin
                    m_mode = M_X; m_busy = 1; m_wait = 20; m_fail = 0;
                    case (m_op)
                       0: begin r = longint'(m_a) + m_b; m_wait = 1; m_fail = (r > 999999); end
                       1: begin r = longint'(m_a) - m_b; m_wait = 1; m_fail = (m_a < m_b); end
                       2: begin r = longint'(m_a) * m_b; m_fail = (r > 999999); end
                       default: begin
                          if (m_b == 0) begin r = 0; m_wait = 1; m_fail = 1; end
                          else r = m_a / m_b;
                       end
                    endcase
                    m_res = int'(r);
                 end
            M_R: if (code <= 9) begin
                    m_a = code; m_dig = 1; m_num = code; m_sign = 5; m_mode = M_A;
                 end else if (code <= DIV) begin
                    m_op = code - 10; m_sign = m_op; m_mode = M_OP;
                 end
            M_E: if (code <= 9) begin
                    m_a = code; m_dig = 1; m_num = code; m_sign = 5; m_err = 0; m_mode = M_A;
                 end
            default: m_mode = M_A;
         endcase
      end
   endfunction

   // one clock: drive on the falling edge, advance the model just after the rising edge
   task automatic cycle(input bit rst, input bit kv, input int code);
      @(negedge clk);
      rst_n     = !rst;
      key_valid = kv;
      key_code  = code[3:0];
      @(posedge clk);
      #1;
      model_step(rst, kv, code);
      key_valid = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic press(input int code);
      cycle(1'b0, 1'b1, code);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_number", {20'd0, number}, m_num[39:0]);
         chk("model_sign",   {37'd0, sign},   m_sign[39:0]);
         chk("model_busy",   {39'd0, busy},   {39'd0, m_busy});
         chk("model_err",    {39'd0, err},    {39'd0, m_err});
      end
   end

   initial begin
      int bc;
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);
      cmp_en = 1'b1;
      chk("reset_number", {20'd0, number}, 40'd0);
      chk("reset_sign",   {37'd0, sign},   40'd5);
      chk("reset_busy",   {39'd0, busy},   40'd0);

      // 123 + 45 = 168, busy exactly one cycle; then chain + 2
      press(1); press(2); press(3); press(ADD);
      chk("add_sign", {37'd0, sign}, 40'd0);
      press(4); press(5); press(EQ);
      chk("add_busy_n", {39'd0, busy}, 40'd1);
      idle(1);
      chk("add_result", {20'd0, number}, 40'd168);
      chk("add_busy_n1", {39'd0, busy}, 40'd0);
      press(ADD); press(2); press(EQ); idle(1);
      chk("chain_result", {20'd0, number}, 40'd170);

      // 999 * 1001 = 999999 over 20 busy cycles
      press(9); press(9); press(9); press(MUL);
      press(1); press(0); press(0); press(1); press(EQ);
      bc = busy;
      for (int i = 0; i < 20; i++) begin idle(1); bc += busy; end
      chk("mul_busy_cycles", bc, 40'd20);
      chk("mul_result", {20'd0, number}, 40'd999999);
      chk("mul_err", {39'd0, err}, 40'd0);

      // 1000 * 1000 overflows
      press(1); press(0); press(0); press(0); press(MUL);
      press(1); press(0); press(0); press(0); press(EQ); idle(20);
      chk("mulovf_err", {39'd0, err}, 40'd1);
      chk("mulovf_sign", {37'd0, sign}, 40'd7);
      chk("mulovf_number", {20'd0, number}, 40'd0);

      // 100 / 7 = 14 at N+20; a digit during busy is ignored
      press(1); press(0); press(0); press(DIV); press(7); press(EQ);
      press(5); idle(18);
      chk("div_busy_n19", {39'd0, busy}, 40'd1);
      idle(1);
      chk("div_result", {20'd0, number}, 40'd14);

      // divide by zero errors at N+1
      press(7); press(DIV); press(0); press(EQ); idle(1);
      chk("div0_err", {39'd0, err}, 40'd1);

      // 5 - 9 underflows; then a 7th digit is ignored
      press(5); press(SUB); press(9); press(EQ); idle(1);
      chk("sub_err", {39'd0, err}, 40'd1);
      press(1); press(2); press(3); press(4); press(5); press(6); press(7);
      chk("seven_digits", {20'd0, number}, 40'd123456);
      press(EQ); press(ADD); press(SUB); press(6); press(ADD); press(EQ); idle(1);
      chk("op_replace", {20'd0, number}, 40'd123450);

      // clear in cycle 10 of a divide
      press(1); press(0); press(0); press(DIV); press(7); press(EQ); idle(9);
      press(CLR);
      chk("clr_busy", {39'd0, busy}, 40'd0);
      chk("clr_number", {20'd0, number}, 40'd0);
      chk("clr_sign", {37'd0, sign}, 40'd4);
      press(5);
      chk("clr_digit_sign", {37'd0, sign}, 40'd5);

      // reset in the middle of a multiply
      press(MUL); press(3); press(EQ); idle(5);
      cycle(1'b1, 1'b0, 0);
      chk("rst_busy", {39'd0, busy}, 40'd0);
      chk("rst_number", {20'd0, number}, 40'd0);
      chk("rst_sign", {37'd0, sign}, 40'd5);
      press(2); press(ADD); press(3); press(EQ); idle(1);
      chk("post_rst_add", {20'd0, number}, 40'd5);

      // add boundaries: 999998+1 fits, 999999+1 overflows
      for (int i = 0; i < 5; i++) press(9);
      press(8); press(ADD); press(1); press(EQ); idle(1);
      chk("add_max", {20'd0, number}, 40'd999999);
      press(ADD); press(1); press(EQ); idle(1);
      chk("add_ovf_err", {39'd0, err}, 40'd1);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state changes on posedge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 key_valid  in  1  one-cycle strobe; key_code is valid in this cycle.
REQ-005 key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 clear, 15 equal.
REQ-006 number  out  20  unsigned value feeding the tube driver, range 0..999999.
REQ-007 sign  out  3  display code: 000 add, 001 sub, 010 mul, 011 div, 100 clear, 101 show number, 111 error.
REQ-008 busy  out  1  high while a computation is in progress.
REQ-009 err  out  1  high while in ERROR.

Function
REQ-010 FSM states SHALL be ENTER_A, OP, ENTER_B, EXEC, RESULT and ERROR.
REQ-011 Registers SHALL be opA[19:0], opB[19:0], op[1:0], a 5-bit iteration counter, a 40-bit accumulator and a digit count.
REQ-012 Digit entry SHALL compute operand <= operand*10 + digit, up to 6 digits per operand.
- A 7th digit SHALL be ignored.
REQ-013 ENTER_A:
- digit: updates opA; number=opA, sign=101.
- operator: latches op; goes to OP.
- equal: ignored.
REQ-014 OP: sign=op code, number=opA.
- another operator: replaces op.
- digit: clears opB, applies the digit, goes to ENTER_B.
- equal: ignored.
REQ-015 ENTER_B: number=opB, sign=101.
- digit: updates opB.
- operator: ignored.
- equal accepted at edge N: goes to EXEC and sets busy=1 at edge N.
REQ-016 EXEC latency:
- add/sub complete in 1 cycle; result, state RESULT and busy=0 appear at edge N+1.
- mul/div iterate 20 cycles; result, state RESULT and busy=0 appear at edge N+20.
REQ-017 mul SHALL be shift-add over the 20 bits of opB, LSB first, into the 40-bit accumulator.
REQ-018 div SHALL be restoring division, 20 iterations MSB first; the quotient is the result and the remainder is discarded.
REQ-019 add overflow: sum >999999 SHALL go to ERROR.
REQ-020 sub underflow: opA<opB SHALL go to ERROR.
REQ-021 mul overflow: 40-bit product >999999 SHALL go to ERROR.
REQ-022 div by zero: opB==0 SHALL go directly from EXEC to ERROR at edge N+1 without iterating.
REQ-023 Every path into ERROR SHALL assert busy=0 on the same edge it enters ERROR.
REQ-024 RESULT: opA<=result, number=result, sign=101.
- operator: latches op, goes to OP (chaining).
- digit: starts a new opA containing that digit, goes to ENTER_A.
- equal: ignored.
REQ-025 ERROR: number=0, sign=111, err=1.
- digit: starts a new opA, goes to ENTER_A with err=0.
- operator and equal: ignored.
REQ-026 All key_valid strobes except clear SHALL be ignored while busy=1.
REQ-027 clear (code 14) SHALL be accepted in every state, including EXEC.
- Effect at the next edge: opA, opB, op, the counter and the accumulator zeroed; state ENTER_A; busy=0; err=0; number=0; sign=100.
- sign SHALL return to 101 on the next accepted digit.
REQ-028 number, sign, busy and err SHALL be registered outputs.
REQ-029 key_valid=0 SHALL leave all state unchanged.

Reset
REQ-030 rst_n=0 at a posedge SHALL force: state ENTER_A, opA=opB=0, op=00, counter=0, accumulator=0, number=0, sign=101, busy=0, err=0.
REQ-031 Reset SHALL take priority over key_valid and over an EXEC in progress.
- Any partial result SHALL be discarded.

Verification
REQ-032 Keys 1,2,3,add,4,5,equal -> sign=000 after add; after equal, number=168, sign=101, busy high exactly 1 cycle.
REQ-033 Keys 9,9,9,mul,1,0,0,1,equal -> busy 20 cycles, then number=999999, err=0.
- Then keys 1,0,0,0,mul,1,0,0,0,equal (opA 1000 entered fresh) -> err=1, sign=111, number=0.
REQ-034 Keys 1,0,0,div,7,equal -> number=14 at edge N+20.
- Keys 7,div,0,equal -> err=1 at edge N+1.
REQ-035 Keys 5,sub,9,equal -> ERROR.
- Keys 1,2,3,4,5,6,7 -> number=123456.
REQ-036 Clear issued in cycle 10 of a div -> next edge: busy=0, number=0, sign=100, state ENTER_A.
- rst_n low mid-EXEC -> all outputs return to their reset values.
